// File: rtl/rand_coord_pkg.sv
// Shared definitions for the rejection-sampling coordinate generator.
package rand_coord_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRAW_X = 2'd1,
    DRAW_Y = 2'd2,
    HOLD   = 2'd3
  } state_t;

  localparam int DEF_H_MAX     = 1280;
  localparam int DEF_V_MAX     = 720;
  localparam int DEF_X_BITS    = 11;
  localparam int DEF_Y_BITS    = 10;
  localparam int DEF_MAX_TRIES = 8;

  // In range -> candidate itself; otherwise fold once (valid because 2^BITS < 2*max).
  function automatic logic [15:0] bounded_sample(input logic [15:0] candidate,
                                                 input logic [15:0] max);
    return (candidate < max) ? candidate : (candidate - max);
  endfunction

endpackage

// File: rtl/rand_coord_sampler.sv
// Turns a free-running LFSR word into uniform (x,y) spawn coordinates with
// bounded rejection sampling and a deterministic fold-down fallback.
module rand_coord_sampler
  import rand_coord_pkg::*;
#(
  parameter int H_MAX     = DEF_H_MAX,
  parameter int V_MAX     = DEF_V_MAX,
  parameter int X_BITS    = DEF_X_BITS,
  parameter int Y_BITS    = DEF_Y_BITS,
  parameter int MAX_TRIES = DEF_MAX_TRIES
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic [15:0]       lfsr_in,
  input  logic              req_in,
  input  logic              ready_in,
  output logic [X_BITS-1:0] x_out,
  output logic [Y_BITS-1:0] y_out,
  output logic              valid_out,
  output logic              busy_out,
  output logic [15:0]       reject_count_out,
  output logic              lfsr_stuck_out
);

  localparam int TRY_W = $clog2(MAX_TRIES) + 1;
  localparam logic [TRY_W-1:0] LAST_TRY = TRY_W'(MAX_TRIES - 1);
  localparam logic [15:0] HMAX16 = 16'(H_MAX);
  localparam logic [15:0] VMAX16 = 16'(V_MAX);

  state_t           state;
  logic [TRY_W-1:0] try_cnt;
  logic             prev_zero;

  logic [15:0] cx, cy;
  logic        x_ok, y_ok, last_try;

  always_comb begin
    cx       = 16'(lfsr_in[X_BITS-1:0]);
    cy       = 16'(lfsr_in[15:16-Y_BITS]);
    x_ok     = cx < HMAX16;
    y_ok     = cy < VMAX16;
    last_try = try_cnt == LAST_TRY;
  end

  assign busy_out = state != IDLE;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state            <= IDLE;
      try_cnt          <= '0;
      prev_zero        <= 1'b0;
      x_out            <= '0;
      y_out            <= '0;
      valid_out        <= 1'b0;
      reject_count_out <= '0;
      lfsr_stuck_out   <= 1'b0;
    end else begin
      // Two consecutive zero words means the LFSR has locked up.
      prev_zero <= lfsr_in == 16'd0;
      if (lfsr_in == 16'd0 && prev_zero) lfsr_stuck_out <= 1'b1;

      case (state)
        IDLE: begin
          if (req_in) begin
            state   <= DRAW_X;
            try_cnt <= '0;
          end
        end
        DRAW_X: begin
          if (!x_ok && reject_count_out != 16'hFFFF)
            reject_count_out <= reject_count_out + 16'd1;
          if (x_ok || last_try) begin
            x_out   <= X_BITS'(bounded_sample(cx, HMAX16));
            try_cnt <= '0;
            state   <= DRAW_Y;
          end else begin
            try_cnt <= try_cnt + 1'b1;
          end
        end
        DRAW_Y: begin
          if (!y_ok && reject_count_out != 16'hFFFF)
            reject_count_out <= reject_count_out + 16'd1;
          if (y_ok || last_try) begin
            y_out     <= Y_BITS'(bounded_sample(cy, VMAX16));
            try_cnt   <= '0;
            valid_out <= 1'b1;
            state     <= HOLD;
          end else begin
            try_cnt <= try_cnt + 1'b1;
          end
        end
        HOLD: begin
          if (ready_in) begin
            valid_out <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
